// File: rtl/filter_window_builder.sv
// -----------------------------------------------------------------------------
// filter_window_builder
//
// Sits behind the filter read-address generator. Pixels come back from the
// frame buffer in 3-row column-raster order (top, middle, bottom for each
// source column). This block assembles a sliding 3x3 window and emits one
// window per completed column once three columns of the current line are held.
// The generator's valid and frame-reset strobes are delayed to line up with
// the frame buffer read latency.
//
// Parameters:
//   PIXEL_WIDTH   bits per pixel
//   READ_LATENCY  cycles from read request to data on pixel_in (>= 1)
//
// Ports:
//   clk_in            system clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   valid_filter_in   read request issued this cycle
//   frame_rst_in      one-cycle new-frame strobe
//   pixel_in          frame buffer read data (READ_LATENCY after request)
//   window_out        3x3 window; element (r,c) at [(3r+c)*PIXEL_WIDTH +: PIXEL_WIDTH]
//   valid_window_out  one-cycle pulse qualifying window_out / win_x_out / win_y_out
//   win_x_out         window index within the line
//   win_y_out         output line index since last frame reset
//   line_done_out     one-cycle pulse at the end of each request burst
// -----------------------------------------------------------------------------
module filter_window_builder #(
    parameter int PIXEL_WIDTH  = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     valid_filter_in,
    input  logic                     frame_rst_in,
    input  logic [PIXEL_WIDTH-1:0]   pixel_in,
    output logic [9*PIXEL_WIDTH-1:0] window_out,
    output logic                     valid_window_out,
    output logic [10:0]              win_x_out,
    output logic [9:0]               win_y_out,
    output logic                     line_done_out
);

    localparam int PW = PIXEL_WIDTH;
    localparam int RL = READ_LATENCY;

    // Delay lines; the tap vectors include the live input at bit 0 so that
    // tap[RL] is the delayed strobe and tap[RL-1] is its next-cycle value.
    logic [RL-1:0] r_vpipe;
    logic [RL-1:0] r_fpipe;
    // Ones shift in after reset; bit RL says the previous delayed-valid sample
    // came from a real input rather than from the reset-cleared pipeline.
    logic [RL:0]   r_kpipe;
    logic [RL:0]   w_vtap;
    logic [RL:0]   w_ftap;

    logic          r_dvalid_q;
    logic          r_active;
    logic          r_emitted;
    logic [1:0]    r_slot;
    logic [1:0]    r_cols;
    logic [10:0]   r_x;
    logic [9:0]    r_y;
    logic [PW-1:0] r_top;
    logic [PW-1:0] r_mid;
    logic [3*PW-1:0] r_col1;        // row r at [r*PW +: PW]
    logic [3*PW-1:0] r_col2;
    logic [9*PW-1:0] r_window;
    logic            r_valid_window;
    logic [10:0]     r_win_x;
    logic [9:0]      r_win_y;
    logic            r_line_done;

    logic            w_dvalid;
    logic            w_dvalid_next;
    logic            w_dfrst;
    logic            w_start;
    logic            w_active;
    logic            w_beat;
    logic            w_end;
    logic [1:0]      w_slot;
    logic [1:0]      w_cols;
    logic [10:0]     w_x;
    logic            w_emitted;
    logic            w_col_done;
    logic            w_emit;
    logic [3*PW-1:0] w_new_col;
    logic [9*PW-1:0] w_win_asm;

    logic [1:0]      w_slot_nx;
    logic [1:0]      w_cols_nx;
    logic [10:0]     w_x_nx;
    logic [9:0]      w_y_nx;
    logic            w_emitted_nx;
    logic            w_active_nx;

    assign w_vtap        = {r_vpipe, valid_filter_in};
    assign w_ftap        = {r_fpipe, frame_rst_in};
    assign w_dvalid      = w_vtap[RL];
    assign w_dvalid_next = w_vtap[RL-1];
    assign w_dfrst       = w_ftap[RL];

    // A line only starts on a genuine low-to-high transition of delayed valid,
    // so a burst already running across reset release is ignored.
    assign w_start    = w_dvalid & ~r_dvalid_q & r_kpipe[RL];
    assign w_active   = r_active | w_start;
    assign w_beat     = w_dvalid & w_active & ~w_dfrst;
    // Line end is taken on the last beat so line_done lands one cycle later.
    assign w_end      = w_dvalid & ~w_dvalid_next & w_active;

    assign w_slot     = w_start ? 2'd0  : r_slot;
    assign w_cols     = w_start ? 2'd0  : r_cols;
    assign w_x        = w_start ? 11'd0 : r_x;
    assign w_emitted  = w_start ? 1'b0  : r_emitted;

    assign w_col_done = w_beat & (w_slot == 2'd2);
    assign w_emit     = w_col_done & (w_cols >= 2'd2);
    assign w_new_col  = {pixel_in, r_mid, r_top};

    // Window assembly: col0 oldest (r_col1), col1 (r_col2), col2 newest column.
    always_comb begin
        w_win_asm = '0;
        for (int r = 0; r < 3; r++) begin
            w_win_asm[(3*r+0)*PW +: PW] = r_col1[r*PW +: PW];
            w_win_asm[(3*r+1)*PW +: PW] = r_col2[r*PW +: PW];
            w_win_asm[(3*r+2)*PW +: PW] = w_new_col[r*PW +: PW];
        end
    end

    // Next-state for slot, fill count, x/y indices and line bookkeeping.
    always_comb begin
        w_slot_nx    = w_slot;
        w_cols_nx    = w_cols;
        w_x_nx       = w_x;
        w_y_nx       = r_y;
        w_emitted_nx = w_emitted;
        w_active_nx  = w_active;
        if (w_end) begin
            w_active_nx = 1'b0;
        end else begin
            w_active_nx = w_active;
        end
        if (w_dfrst) begin
            w_slot_nx    = 2'd0;
            w_cols_nx    = 2'd0;
            w_x_nx       = 11'd0;
            w_y_nx       = 10'd0;
            w_emitted_nx = 1'b0;
        end else begin
            if (w_end) begin
                // Partial column is discarded; completed column also lands on 0.
                w_slot_nx = 2'd0;
            end else if (w_beat) begin
                case (w_slot)
                    2'd0:    w_slot_nx = 2'd1;
                    2'd1:    w_slot_nx = 2'd2;
                    default: w_slot_nx = 2'd0;
                endcase
            end else begin
                w_slot_nx = w_slot;
            end
            if (w_col_done && (w_cols != 2'd3)) begin
                w_cols_nx = w_cols + 2'd1;
            end else begin
                w_cols_nx = w_cols;
            end
            if (w_emit) begin
                w_x_nx       = w_x + 11'd1;
                w_emitted_nx = 1'b1;
            end else begin
                w_x_nx       = w_x;
                w_emitted_nx = w_emitted;
            end
            if (w_end && (w_emitted || w_emit)) begin
                w_y_nx = r_y + 10'd1;
            end else begin
                w_y_nx = r_y;
            end
        end
    end

    // Strobe delay lines and reset-qualification pipeline.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_vpipe    <= '0;
            r_fpipe    <= '0;
            r_kpipe    <= '0;
            r_dvalid_q <= 1'b0;
        end else begin
            r_vpipe    <= w_vtap[RL-1:0];
            r_fpipe    <= w_ftap[RL-1:0];
            r_kpipe    <= {r_kpipe[RL-1:0], 1'b1};
            r_dvalid_q <= w_dvalid;
        end
    end

    // Control state and pixel/column capture.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_active  <= 1'b0;
            r_emitted <= 1'b0;
            r_slot    <= 2'd0;
            r_cols    <= 2'd0;
            r_x       <= 11'd0;
            r_y       <= 10'd0;
            r_top     <= '0;
            r_mid     <= '0;
            r_col1    <= '0;
            r_col2    <= '0;
        end else begin
            r_active  <= w_active_nx;
            r_emitted <= w_emitted_nx;
            r_slot    <= w_slot_nx;
            r_cols    <= w_cols_nx;
            r_x       <= w_x_nx;
            r_y       <= w_y_nx;
            if (w_beat && (w_slot == 2'd0)) begin
                r_top <= pixel_in;
            end
            if (w_beat && (w_slot == 2'd1)) begin
                r_mid <= pixel_in;
            end
            if (w_col_done) begin
                r_col1 <= r_col2;
                r_col2 <= w_new_col;
            end
        end
    end

    // Registered outputs; window and indices hold between pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_window       <= '0;
            r_valid_window <= 1'b0;
            r_win_x        <= 11'd0;
            r_win_y        <= 10'd0;
            r_line_done    <= 1'b0;
        end else begin
            r_valid_window <= w_emit;
            r_line_done    <= w_end;
            if (w_emit) begin
                r_window <= w_win_asm;
                r_win_x  <= w_x;
                r_win_y  <= r_y;
            end
        end
    end

    assign window_out       = r_window;
    assign valid_window_out = r_valid_window;
    assign win_x_out        = r_win_x;
    assign win_y_out        = r_win_y;
    assign line_done_out    = r_line_done;

endmodule

// File: tb/tb_filter_window_builder.sv
// Directed bench for filter_window_builder (PIXEL_WIDTH=8, READ_LATENCY=2).
module tb_filter_window_builder;

    localparam int PW = 8;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic            frst;
    logic [PW-1:0]   req_pix;
    logic [PW-1:0]   pixel;
    logic [9*PW-1:0] window;
    logic            vwin;
    logic [10:0]     wx;
    logic [9:0]      wy;
    logic            ldone;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor storage
    logic [10:0]     px [0:511];
    logic [9:0]      py [0:511];
    logic [9*PW-1:0] pw [0:511];
    int              pc [0:511];
    int              ldc [0:63];
    int              np = 0;
    int              nl = 0;

    int req9;
    int reqlast;
    int b;
    int l;

    logic [PW-1:0] mem_pipe [0:RL-1];

    filter_window_builder #(.PIXEL_WIDTH(PW), .READ_LATENCY(RL)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .valid_filter_in  (valid),
        .frame_rst_in     (frst),
        .pixel_in         (pixel),
        .window_out       (window),
        .valid_window_out (vwin),
        .win_x_out        (wx),
        .win_y_out        (wy),
        .line_done_out    (ldone)
    );

    always #5 clk = ~clk;

    // Frame buffer model: data for a request appears RL cycles later.
    always @(posedge clk) begin
        mem_pipe[0] <= req_pix;
        for (int i = 1; i < RL; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
    assign pixel = mem_pipe[RL-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Record pulses away from the active edge.
    always @(negedge clk) begin
        if (vwin === 1'b1 && np < 512) begin
            px[np] <= wx;
            py[np] <= wy;
            pw[np] <= window;
            pc[np] <= cyc;
            np     <= np + 1;
        end
        if (ldone === 1'b1 && nl < 64) begin
            ldc[nl] <= cyc;
            nl      <= nl + 1;
        end
    end

    // mode 0: col*16+row ; mode 1: column number
    function automatic logic [PW-1:0] pixf(input int beat, input int mode);
        int col;
        int row;
        col = beat / 3;
        row = beat % 3;
        if (mode == 1) return PW'(col);
        else           return PW'(col * 16 + row);
    endfunction

    // Expected window k of a line whose first consumed beat is 'off'.
    function automatic logic [9*PW-1:0] expw(input int k, input int off, input int mode);
        logic [9*PW-1:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*PW +: PW] = pixf(off + 3*(k+c) + r, mode);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_reset();
        @(negedge clk); frst = 1'b1;
        @(negedge clk); frst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // n-beat burst; frame_rst_in raised together with beat frst_at (-1 = none)
    task automatic burst(input int n, input int mode, input int frst_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid   = 1'b1;
            req_pix = pixf(i, mode);
            frst    = (i == frst_at);
            if (i == 8)     req9    = cyc;
            if (i == n - 1) reqlast = cyc;
        end
        @(negedge clk);
        valid = 1'b0; frst = 1'b0; req_pix = '0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; frst = 1'b0; req_pix = '0;
        repeat (3) @(negedge clk);
        chk("rst_window", 128'(window), 128'(0));
        chk("rst_valid",  128'(vwin),   128'(0));
        chk("rst_ldone",  128'(ldone),  128'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Reset mid-line, then a burst carried across reset release
        frame_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            valid = 1'b1; req_pix = pixf(i, 0);
        end
        #2;
        chk("pre_rst_x", 128'(wx), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_window", 128'(window), 128'(0));
        chk("mid_rst_valid",  128'(vwin),   128'(0));
        chk("mid_rst_x",      128'(wx),     128'(0));
        chk("mid_rst_y",      128'(wy),     128'(0));
        chk("mid_rst_ldone",  128'(ldone),  128'(0));
        b = np; l = nl;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            valid = 1'b1; req_pix = pixf(i, 0);
        end
        @(negedge clk); valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("resume_no_pulse", 128'(np - b), 128'(0));
        chk("resume_no_ldone", 128'(nl - l), 128'(0));

        // 2. Basic 15-beat line
        frame_reset();
        b = np; l = nl;
        burst(15, 0, -1);
        chk("basic_count", 128'(np - b), 128'(3));
        for (int k = 0; k < 3; k++) begin
            chk("basic_x",   128'(px[b+k]), 128'(k));
            chk("basic_y",   128'(py[b+k]), 128'(0));
            chk("basic_win", 128'(pw[b+k]), 128'(expw(k, 0, 0)));
        end
        chk("basic_lat",    128'(pc[b] - req9),       128'(3));
        chk("basic_gap1",   128'(pc[b+1] - pc[b]),    128'(3));
        chk("basic_gap2",   128'(pc[b+2] - pc[b+1]),  128'(3));
        chk("basic_ldone",  128'(nl - l),             128'(1));
        chk("basic_ld_lat", 128'(ldc[l] - reqlast),   128'(3));

        // 3. Full 399-beat line (pixel = column number)
        b = np;
        burst(399, 1, -1);
        chk("full_count",  128'(np - b),       128'(131));
        chk("full_first_x", 128'(px[b]),       128'(0));
        chk("full_last_x", 128'(px[b+130]),    128'(130));
        chk("full_last_win", 128'(pw[b+130]),  128'(expw(130, 0, 1)));
        for (int r = 0; r < 3; r++)
            chk("full_col2", 128'(pw[b+130][(3*r+2)*PW +: PW]), 128'(8'h84));

        // 4. Frame sequence
        frame_reset();
        for (int n = 0; n < 3; n++) begin
            b = np;
            burst(15, 0, -1);
            chk("frame_y", 128'(py[b]), 128'(n));
        end
        frame_reset();
        b = np;
        burst(15, 0, -1);
        chk("frame2_y", 128'(py[b]), 128'(0));

        // 5. Partial line then a minimal 9-beat line
        frame_reset();
        b = np; l = nl;
        burst(8, 0, -1);
        chk("partial_none",  128'(np - b), 128'(0));
        chk("partial_ldone", 128'(nl - l), 128'(1));
        b = np;
        burst(9, 0, -1);
        chk("nine_count", 128'(np - b), 128'(1));
        chk("nine_x",     128'(px[b]),  128'(0));
        chk("nine_y",     128'(py[b]),  128'(0));
        chk("nine_win",   128'(pw[b]),  128'(expw(0, 0, 0)));

        // 6. Frame reset coinciding with the first beat drops that beat
        b = np;
        burst(10, 0, 0);
        chk("prio_count", 128'(np - b), 128'(1));
        chk("prio_x",     128'(px[b]),  128'(0));
        chk("prio_y",     128'(py[b]),  128'(0));
        chk("prio_win",   128'(pw[b]),  128'(expw(0, 1, 0)));
        b = np;
        burst(9, 0, -1);
        chk("prio_next_count", 128'(np - b), 128'(1));
        chk("prio_next_y",     128'(py[b]),  128'(1));
        chk("prio_next_win",   128'(pw[b]),  128'(expw(0, 0, 0)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
